// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl -- vending machine controller
//
// Collects coins into a credit register. Requests one item once the credit
// covers PRICE, then pays back any remaining credit one unit per cycle. A
// cancel refunds all credit. Coins that are invalid, that would overflow the
// credit register, or that arrive while dispensing or paying change are
// rejected.
//
// Parameters
//   PRICE     item price in credit units (1..10)
//   CREDIT_W  credit register width
//   TIMEOUT   inactivity refund limit in cycles (used only with the macro)
//
// Ports
//   sys_clk    in   single clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   coin_vld   in   one-cycle coin insertion strobe
//   coin_val   in   coin code: 1 = 1 unit, 2 = 2 units, 3 = 5 units, 0 = invalid
//   cancel     in   request refund of all credit
//   disp_req   out  request one item from the dispenser (registered)
//   disp_ack   in   dispenser confirms the item was delivered
//   chg_pulse  out  one credit unit returned per high cycle (registered)
//   coin_rej   out  one-cycle pulse when a coin is rejected (registered)
//   credit     out  current credit register
//   busy       out  high whenever the state is not IDLE (registered)
//
// Build option
//   VEND_REFUND_TIMEOUT_EN  when defined, COLLECT refunds after TIMEOUT
//                           cycles without a coin; otherwise it waits forever.
// -----------------------------------------------------------------------------
module vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                coin_vld,
    input  logic [1:0]          coin_val,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                chg_pulse,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispReq_q, dispReq_d;
    logic                chgPulse_q, chgPulse_d;
    logic                coinRej_q, coinRej_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coinUnits;
    logic [CREDIT_W:0]   creditSum;
    logic                timeoutHit;

    // Decode the coin code into credit units. The sum is one bit wider than
    // the credit register so an overflowing coin shows up in the top bit.
    always_comb begin
        coinUnits = '0;
        case (coin_val)
            2'd1:    coinUnits = (CREDIT_W+1)'(1);
            2'd2:    coinUnits = (CREDIT_W+1)'(2);
            2'd3:    coinUnits = (CREDIT_W+1)'(5);
            default: coinUnits = '0;
        endcase
        creditSum = {1'b0, credit_q} + coinUnits;
    end

`ifdef VEND_REFUND_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] toutCnt_q, toutCnt_d;

    // Inactivity counter: held at zero outside COLLECT so it starts from zero
    // on entry, cleared by any coin, otherwise counts COLLECT cycles.
    always_comb begin
        toutCnt_d = '0;
        if (state_q == COLLECT && !coin_vld) begin
            toutCnt_d = toutCnt_q + 1'b1;
        end
        timeoutHit = (state_q == COLLECT) && !coin_vld && (toutCnt_d == CntW'(TIMEOUT));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            toutCnt_q <= '0;
        end else begin
            toutCnt_q <= toutCnt_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state and next-output logic. Outputs are computed from the next
    // state so the registered versions line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        coinRej_d = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (coin_vld) begin
                    if (coin_val == 2'd0 || creditSum[CREDIT_W]) begin
                        coinRej_d = 1'b1;
                    end else begin
                        credit_d = creditSum[CREDIT_W-1:0];
                    end
                end
                // Cancel beats a same-cycle coin that reaches the price;
                // that coin is still credited and then refunded.
                if (cancel) begin
                    state_d = CHANGE;
                end else if (credit_d >= PriceC) begin
                    state_d = DISPENSE;
                end else if (credit_d != credit_q) begin
                    state_d = COLLECT;
                end else if (timeoutHit) begin
                    state_d = CHANGE;
                end
            end
            DISPENSE: begin
                coinRej_d = coin_vld;
                if (disp_ack) begin
                    credit_d = credit_q - PriceC;
                    state_d  = CHANGE;
                end
            end
            CHANGE: begin
                coinRej_d = coin_vld;
                if (credit_q != '0) begin
                    credit_d = credit_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dispReq_d  = (state_d == DISPENSE);
        chgPulse_d = (state_d == CHANGE) && (credit_d != '0);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction without refund.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispReq_q  <= 1'b0;
            chgPulse_q <= 1'b0;
            coinRej_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispReq_q  <= dispReq_d;
            chgPulse_q <= chgPulse_d;
            coinRej_q  <= coinRej_d;
            busy_q     <= busy_d;
        end
    end

    assign disp_req  = dispReq_q;
    assign chg_pulse = chgPulse_q;
    assign coin_rej  = coinRej_q;
    assign credit    = credit_q;
    assign busy      = busy_q;

endmodule
